// File: rtl/sdram_cmd_ctrl.sv
// SDRAM command controller: power-up init, periodic refresh,
// 8-halfword read bursts and paired halfword writes for one port.
`timescale 1ns/1ps
module sdram_cmd_ctrl #(
  parameter int CAS_LAT    = 2,
  parameter int T_RCD      = 2,
  parameter int T_RP       = 2,
  parameter int T_RFC      = 7,
  parameter int T_WR       = 2,
  parameter int REF_PERIOD = 780,
  parameter int INIT_WAIT  = 20000
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic        acc_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [15:0] dat_i,
  input  logic [1:0]  sel_i,
  output logic        ack_o,
  output logic [31:0] adr_o,
  output logic [15:0] dat_o,
  output logic [3:0]  sdram_cmd_o,
  output logic [1:0]  sdram_ba_o,
  output logic [12:0] sdram_a_o,
  output logic        sdram_cke_o,
  output logic [1:0]  sdram_dqm_o,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe_o,
  input  logic [15:0] sdram_dq_i
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int TMAX = INIT_WAIT + T_RFC + T_RP + T_WR
                      + T_RCD + CAS_LAT + 16;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW = $clog2(REF_PERIOD + 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_ACT, S_RD, S_RD_DATA,
    S_WR_HI, S_WR_LO, S_REF, S_WAIT
  } st_e;

  st_e           state_q, state_d, ret_q, ret_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    ip_q, ip_d;
  logic          init_done_q, init_done_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [15:0]   wdat_q, wdat_d;
  logic [1:0]    sel_q, sel_d;
  logic          ack_q, ack_d;
  logic [31:0]   radr_q, radr_d;
  logic [15:0]   rdat_q, rdat_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [1:0]    ba_q, ba_d;
  logic [12:0]   a_q, a_d;
  logic [1:0]    dqm_q, dqm_d;
  logic [15:0]   dq_q, dq_d;
  logic          oe_q, oe_d;
  logic          rst_sync_q;
  logic          go_wait;
  int            wait_n;
  st_e           wait_ret;
  logic [2:0]    beat;
  logic          unused_bits;

  assign unused_bits = adr_q[0];

  // Deassertion is retimed to the clock; assertion stays asynchronous.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) rst_sync_q <= 1'b1;
    else           rst_sync_q <= 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    tmr_d       = tmr_q;
    ip_d        = ip_q;
    init_done_d = init_done_q;
    ref_cnt_d   = ref_cnt_q;
    ref_pend_d  = ref_pend_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    sel_d       = sel_q;
    ack_d       = 1'b0;
    radr_d      = radr_q;
    rdat_d      = rdat_q;
    cmd_d       = CMD_NOP;
    ba_d        = ba_q;
    a_d         = a_q;
    dqm_d       = 2'b11;
    dq_d        = '0;
    oe_d        = 1'b0;
    go_wait     = 1'b0;
    wait_n      = 0;
    wait_ret    = S_IDLE;
    beat        = adr_q[3:1] + ~tmr_q[2:0];

    unique case (state_q)
      S_WAIT: begin
        if (tmr_q == '0) state_d = ret_q;
        else             tmr_d = tmr_q - 1'b1;
      end
      S_INIT: begin
        go_wait  = 1'b1;
        ip_d     = ip_q + 2'd1;
        wait_ret = S_INIT;
        unique case (ip_q)
          2'd0:      wait_n = T_RP;
          2'd1, 2'd2: wait_n = T_RFC;
          default: begin
            wait_n   = 2;
            wait_ret = S_IDLE;
          end
        endcase
      end
      S_IDLE: begin
        if (ref_pend_q) begin
          state_d = S_REF;
        end else if (acc_i) begin
          state_d = S_ACT;
          we_d    = we_i;
          adr_d   = adr_i;
          wdat_d  = dat_i;
          sel_d   = sel_i;
        end
      end
      S_ACT: begin
        go_wait  = 1'b1;
        wait_n   = T_RCD;
        wait_ret = we_q ? S_WR_HI : S_RD;
      end
      S_RD: begin
        state_d = S_RD_DATA;
        tmr_d   = TW'(CAS_LAT + 6);
      end
      // tmr 7..0 marks the eight cycles the pad carries burst data
      S_RD_DATA: begin
        if (tmr_q <= TW'(7)) begin
          rdat_d = sdram_dq_i;
          radr_d = {adr_q[31:4], beat, 1'b0};
          ack_d  = (tmr_q == TW'(7));
        end
        if (tmr_q == '0) begin
          go_wait = 1'b1;
          wait_n  = T_RP + 1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_WR_HI: state_d = S_WR_LO;
      S_WR_LO: begin
        go_wait = 1'b1;
        wait_n  = T_WR + T_RP;
      end
      S_REF: begin
        go_wait = 1'b1;
        wait_n  = T_RFC - 1;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_wait) begin
      if (wait_n <= 1) begin
        state_d = wait_ret;
      end else begin
        state_d = S_WAIT;
        ret_d   = wait_ret;
        tmr_d   = TW'(wait_n - 2);
      end
    end

    unique case (state_d)
      S_INIT: begin
        ba_d = 2'b00;
        unique case (ip_d)
          2'd0: begin
            cmd_d = CMD_PRE;
            a_d   = 13'h0400;
          end
          2'd1, 2'd2: cmd_d = CMD_REF;
          default: begin
            cmd_d = CMD_MRS;
            a_d   = {3'b000, 1'b1, 2'b00, 3'(CAS_LAT), 1'b0, 3'b011};
          end
        endcase
      end
      S_REF: cmd_d = CMD_REF;
      S_ACT: begin
        cmd_d = CMD_ACT;
        ba_d  = adr_d[24:23];
        a_d   = adr_d[22:10];
      end
      S_RD: begin
        cmd_d = CMD_RD;
        ba_d  = adr_q[24:23];
        a_d   = {2'b00, 1'b1, 1'b0, adr_q[9:1]};
        dqm_d = 2'b00;
      end
      S_RD_DATA: dqm_d = 2'b00;
      S_WR_HI: begin
        cmd_d = CMD_WR;
        ba_d  = adr_q[24:23];
        a_d   = {2'b00, 1'b0, 1'b0, adr_q[9:1]};
        dq_d  = wdat_q;
        dqm_d = ~sel_q;
        oe_d  = 1'b1;
      end
      // second halfword comes live from the requester
      S_WR_LO: begin
        cmd_d = CMD_WR;
        ba_d  = adr_q[24:23];
        a_d   = {2'b00, 1'b1, 1'b0, adr_i[9:1]};
        dq_d  = dat_i;
        dqm_d = ~sel_i;
        oe_d  = 1'b1;
        ack_d = 1'b1;
      end
      default: ;
    endcase

    init_done_d = init_done_q | (state_d == S_IDLE);
    if (state_d == S_REF) ref_pend_d = 1'b0;
    if (init_done_q) begin
      if (ref_cnt_q == RW'(REF_PERIOD - 1)) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sdram_clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      state_q     <= S_WAIT;
      ret_q       <= S_INIT;
      tmr_q       <= TW'(INIT_WAIT - 1);
      ip_q        <= 2'd0;
      init_done_q <= 1'b0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      ack_q       <= 1'b0;
      radr_q      <= '0;
      rdat_q      <= '0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      a_q         <= '0;
      dqm_q       <= 2'b11;
      dq_q        <= '0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      tmr_q       <= tmr_d;
      ip_q        <= ip_d;
      init_done_q <= init_done_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      sel_q       <= sel_d;
      ack_q       <= ack_d;
      radr_q      <= radr_d;
      rdat_q      <= rdat_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      a_q         <= a_d;
      dqm_q       <= dqm_d;
      dq_q        <= dq_d;
      oe_q        <= oe_d;
    end
  end

  assign ack_o         = ack_q;
  assign adr_o         = radr_q;
  assign dat_o         = rdat_q;
  assign sdram_cmd_o   = cmd_q;
  assign sdram_ba_o    = ba_q;
  assign sdram_a_o     = a_q;
  assign sdram_cke_o   = 1'b1;
  assign sdram_dqm_o   = dqm_q;
  assign sdram_dq_o    = dq_q;
  assign sdram_dq_oe_o = oe_q;

endmodule

// File: tb/tb_sdram_cmd_ctrl.sv
// Directed bench for sdram_cmd_ctrl: init, read burst, write pair,
// refresh-vs-request priority and reset during a read burst.
`timescale 1ns/1ps
module tb_sdram_cmd_ctrl;

  localparam int CL   = 2;
  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int TWR  = 2;
  localparam int REFP = 100;
  localparam int IW   = 10;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        acc_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] adr_i = '0;
  logic [15:0] dat_i = '0;
  logic [1:0]  sel_i = 2'b11;
  logic        ack_o;
  logic [31:0] adr_o;
  logic [15:0] dat_o;
  logic [3:0]  sdram_cmd_o;
  logic [1:0]  sdram_ba_o;
  logic [12:0] sdram_a_o;
  logic        sdram_cke_o;
  logic [1:0]  sdram_dqm_o;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe_o;
  logic [15:0] sdram_dq_i = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdram_cmd_ctrl #(
    .CAS_LAT(CL), .T_RCD(TRCD), .T_RP(TRP), .T_RFC(TRFC),
    .T_WR(TWR), .REF_PERIOD(REFP), .INIT_WAIT(IW)
  ) dut (
    .sdram_clk(clk), .sdram_rst(rst),
    .acc_i(acc_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .sel_i(sel_i), .ack_o(ack_o),
    .adr_o(adr_o), .dat_o(dat_o),
    .sdram_cmd_o(sdram_cmd_o), .sdram_ba_o(sdram_ba_o),
    .sdram_a_o(sdram_a_o), .sdram_cke_o(sdram_cke_o),
    .sdram_dqm_o(sdram_dqm_o), .sdram_dq_o(sdram_dq_o),
    .sdram_dq_oe_o(sdram_dq_oe_o), .sdram_dq_i(sdram_dq_i)
  );

  // SDRAM read-data model: beat j of a burst is 16'hA000 + j,
  // on the pad CL cycles after READ.
  int rd_t = -1;
  always @(negedge clk) begin
    if (rst) begin
      rd_t = -1;
    end else begin
      if (rd_t >= 0) rd_t++;
      if (sdram_cmd_o == RD) rd_t = 0;
    end
    if (rd_t >= CL && rd_t < CL + 8)
      sdram_dq_i = 16'hA000 + 16'(rd_t - CL);
    else
      sdram_dq_i = 16'h0000;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cmd(input int bound, output int dly);
    dly = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (sdram_cmd_o !== NOP) begin
        dly = i;
        break;
      end
    end
  endtask

  task automatic count_nops(output int n, output logic acked);
    n = 0;
    acked = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack_o) acked = 1'b1;
      if (sdram_cmd_o !== NOP) break;
      n++;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack"}, 32'(ack_o), 32'h0);
    chk({tag, "_dat"}, 32'(dat_o), 32'h0);
    chk({tag, "_adr"}, adr_o, 32'h0);
    chk({tag, "_cmd"}, 32'(sdram_cmd_o), 32'(NOP));
    chk({tag, "_cke"}, 32'(sdram_cke_o), 32'h1);
    chk({tag, "_oe"}, 32'(sdram_dq_oe_o), 32'h0);
    chk({tag, "_dqm"}, 32'(sdram_dqm_o), 32'h3);
  endtask

  logic [31:0] rd_adr_exp [8];
  initial begin
    rd_adr_exp[0] = 32'h46; rd_adr_exp[1] = 32'h48;
    rd_adr_exp[2] = 32'h4A; rd_adr_exp[3] = 32'h4C;
    rd_adr_exp[4] = 32'h4E; rd_adr_exp[5] = 32'h40;
    rd_adr_exp[6] = 32'h42; rd_adr_exp[7] = 32'h44;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    int w;
    logic acked;
    logic got_ref;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("por");

    rst = 1'b0;
    count_nops(n, acked);
    chk("init_nops", 32'(n), 32'(IW));
    chk("init_pre", 32'(sdram_cmd_o), 32'(PRE));
    chk("init_pre_a", 32'(sdram_a_o), 32'h400);
    next_cmd(20, d);
    chk("init_ref1", 32'(sdram_cmd_o), 32'(REF));
    chk("init_trp", 32'(d), 32'(TRP));
    next_cmd(20, d);
    chk("init_ref2", 32'(sdram_cmd_o), 32'(REF));
    chk("init_trfc1", 32'(d), 32'(TRFC));
    next_cmd(20, d);
    chk("init_mrs", 32'(sdram_cmd_o), 32'(MRS));
    chk("init_trfc2", 32'(d), 32'(TRFC));
    chk("init_mrs_a", 32'(sdram_a_o), 32'h223);
    chk("init_mrs_ba", 32'(sdram_ba_o), 32'h0);

    acc_i = 1'b1;
    we_i  = 1'b0;
    adr_i = 32'h0000_0046;
    next_cmd(20, d);
    chk("rd_act", 32'(sdram_cmd_o), 32'(ACT));
    chk("rd_mrs_to_act", 32'(d), 32'd3);
    chk("rd_act_row", 32'(sdram_a_o), 32'h0);
    chk("rd_act_ba", 32'(sdram_ba_o), 32'h0);
    next_cmd(20, d);
    chk("rd_read", 32'(sdram_cmd_o), 32'(RD));
    chk("rd_trcd", 32'(d), 32'(TRCD));
    chk("rd_read_a", 32'(sdram_a_o), 32'h423);
    chk("rd_dqm", 32'(sdram_dqm_o), 32'h0);
    w = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack_o) begin
        w = i;
        break;
      end
    end
    chk("rd_ack_lat", 32'(w), 32'(CL + 1));
    acc_i = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b > 0) @(negedge clk);
      chk($sformatf("rd_adr%0d", b), adr_o, rd_adr_exp[b]);
      chk($sformatf("rd_dat%0d", b), 32'(dat_o), 32'hA000 + 32'(b));
      chk($sformatf("rd_ack%0d", b), 32'(ack_o), 32'(b == 0));
    end

    acc_i = 1'b1;
    we_i  = 1'b1;
    adr_i = 32'h0000_0100;
    dat_i = 16'hAAAA;
    sel_i = 2'b11;
    next_cmd(20, d);
    chk("wr_act", 32'(sdram_cmd_o), 32'(ACT));
    chk("wr_act_row", 32'(sdram_a_o), 32'h0);
    next_cmd(20, d);
    chk("wr_hi", 32'(sdram_cmd_o), 32'(WR));
    chk("wr_trcd", 32'(d), 32'(TRCD));
    chk("wr_hi_a", 32'(sdram_a_o), 32'h080);
    chk("wr_hi_dq", 32'(sdram_dq_o), 32'hAAAA);
    chk("wr_hi_oe", 32'(sdram_dq_oe_o), 32'h1);
    chk("wr_hi_dqm", 32'(sdram_dqm_o), 32'h0);
    chk("wr_hi_ack", 32'(ack_o), 32'h0);
    adr_i = 32'h0000_0102;
    dat_i = 16'h5555;
    @(negedge clk);
    chk("wr_lo", 32'(sdram_cmd_o), 32'(WR));
    chk("wr_lo_a", 32'(sdram_a_o), 32'h481);
    chk("wr_lo_dq", 32'(sdram_dq_o), 32'h5555);
    chk("wr_lo_oe", 32'(sdram_dq_oe_o), 32'h1);
    chk("wr_lo_ack", 32'(ack_o), 32'h1);
    acc_i = 1'b0;
    @(negedge clk);
    chk("wr_post_ack", 32'(ack_o), 32'h0);
    chk("wr_post_oe", 32'(sdram_dq_oe_o), 32'h0);

    // Back-to-back reads until a refresh lands on a pending request.
    acc_i = 1'b1;
    we_i  = 1'b0;
    adr_i = 32'h0180_0C0A;
    got_ref = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sdram_cmd_o == REF) begin
        got_ref = 1'b1;
        break;
      end
    end
    chk("ref_seen", 32'(got_ref), 32'h1);
    next_cmd(20, d);
    chk("ref_then_act", 32'(sdram_cmd_o), 32'(ACT));
    chk("ref_trfc", 32'(d), 32'(TRFC));
    chk("ref_act_ba", 32'(sdram_ba_o), 32'h3);
    chk("ref_act_row", 32'(sdram_a_o), 32'h3);

    w = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack_o) begin
        w = i;
        break;
      end
    end
    chk("rst_rd_ack", 32'(w), 32'(TRCD + CL + 1));
    chk("rst_rd_adr", adr_o, 32'h0180_0C0A);
    acc_i = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outs("mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_nops(n, acked);
    chk("reinit_nops", 32'(n), 32'(IW));
    chk("reinit_pre", 32'(sdram_cmd_o), 32'(PRE));
    chk("reinit_no_ack", 32'(acked), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
